dualedge_lane_scheduler: RTL

- Round-robin scheduler that shares one double-data-rate output lane between NREQ requesters.
- Each accepted WIDTH-bit word is serialized two bits per clk cycle, as a rise/fall bit pair. The pair feeds a posedge/negedge flop cell that drives both clock edges.
- Arbitration is per packet. The owner holds the lane until it marks its last word, then a one-cycle gap precedes re-arbitration.

---
 rtl/dualedge_lane_scheduler.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/dualedge_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dualedge_lane_scheduler
// Purpose  : Round-robin, per-packet arbiter that shares one double-data-rate
//            output lane between NREQ requesters. Each granted WIDTH-bit word
//            is sent as rise/fall bit pairs, one pair per clk cycle, MSB first.
// Options  : DUALEDGE_SCHED_PARITY_EN - append an even-parity pair after every
//            word (rise = ^word, fall = ~rise).
// Revision : 1.0 - initial release
// ============================================================================
module dualedge_lane_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   data_in,
    input  logic [NREQ-1:0]         last_in,
    output logic [NREQ-1:0]         grant,
    output logic                    rise_bit,
    output logic                    fall_bit,
    output logic                    lane_en,
    output logic                    busy,
    output logic [IDX_W-1:0]        owner
);

    localparam int PAIRS = WIDTH / 2;
`ifdef DUALEDGE_SCHED_PARITY_EN
    // The parity pair occupies one extra slot after the data pairs.
    localparam int END_CNT = PAIRS;
`else
    localparam int END_CNT = PAIRS - 1;
`endif
    localparam int CNT_W = (END_CNT > 0) ? $clog2(END_CNT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             state, state_n;
    logic [IDX_W-1:0]   owner_n;
    logic [IDX_W-1:0]   rr_ptr, rr_n;
    logic [WIDTH-1:0]   shreg, shreg_n;
    logic [CNT_W-1:0]   pair_cnt, cnt_n;
    logic               last_q, last_n;
    logic               rise_n, fall_n, lane_n;
    logic [NREQ-1:0]    grant_c;
    logic               load;
    logic [IDX_W-1:0]   load_idx;
    logic [WIDTH-1:0]   load_word;
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
`ifdef DUALEDGE_SCHED_PARITY_EN
    logic               par_q, par_n;
`endif

    // Round-robin search: first requester at or above rr_ptr, with wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!pick_found && req[(int'(rr_ptr) + k) % NREQ]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'((int'(rr_ptr) + k) % NREQ);
            end
        end
    end

    // Next-state and next-output logic; a "load" captures a word and puts its
    // first pair straight into the output flops, so shreg keeps the remainder.
    always_comb begin
        state_n   = state;
        owner_n   = owner;
        rr_n      = rr_ptr;
        shreg_n   = shreg;
        cnt_n     = pair_cnt;
        last_n    = last_q;
        rise_n    = 1'b0;
        fall_n    = 1'b0;
        lane_n    = 1'b0;
        grant_c   = '0;
        load      = 1'b0;
        load_idx  = owner;
`ifdef DUALEDGE_SCHED_PARITY_EN
        par_n     = par_q;
`endif

        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    load     = 1'b1;
                    load_idx = pick_idx;
                end
            end
            S_SHIFT: begin
                if (pair_cnt == CNT_W'(END_CNT)) begin
                    // Final slot of the word is on the lane right now.
                    if (last_q) begin
                        state_n = S_GAP;
                        rr_n    = (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;
                    end else if (req[owner]) begin
                        load     = 1'b1;
                        load_idx = owner;
                    end
                    // Otherwise stall: lane idles, still locked to owner.
                end
`ifdef DUALEDGE_SCHED_PARITY_EN
                else if (pair_cnt == CNT_W'(PAIRS - 1)) begin
                    rise_n = par_q;
                    fall_n = ~par_q;
                    lane_n = 1'b1;
                    cnt_n  = pair_cnt + 1'b1;
                end
`endif
                else begin
                    rise_n  = shreg[WIDTH-1];
                    fall_n  = shreg[WIDTH-2];
                    lane_n  = 1'b1;
                    shreg_n = shreg << 2;
                    cnt_n   = pair_cnt + 1'b1;
                end
            end
            S_GAP: begin
                state_n = S_IDLE;
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        load_word = data_in[int'(load_idx)*WIDTH +: WIDTH];
        if (load) begin
            grant_c[load_idx] = 1'b1;
            owner_n           = load_idx;
            last_n            = last_in[load_idx];
            rise_n            = load_word[WIDTH-1];
            fall_n            = load_word[WIDTH-2];
            lane_n            = 1'b1;
            shreg_n           = load_word << 2;
            cnt_n             = '0;
            state_n           = S_SHIFT;
`ifdef DUALEDGE_SCHED_PARITY_EN
            par_n             = ^load_word;
`endif
        end
    end

    // Grant is suppressed during reset so an aborted or pending word is never accepted.
    assign grant = reset ? '0 : grant_c;
    assign busy  = (state != S_IDLE);

    // State and lane output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            owner    <= '0;
            rr_ptr   <= '0;
            shreg    <= '0;
            pair_cnt <= '0;
            last_q   <= 1'b0;
            rise_bit <= 1'b0;
            fall_bit <= 1'b0;
            lane_en  <= 1'b0;
`ifdef DUALEDGE_SCHED_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state    <= state_n;
            owner    <= owner_n;
            rr_ptr   <= rr_n;
            shreg    <= shreg_n;
            pair_cnt <= cnt_n;
            last_q   <= last_n;
            rise_bit <= rise_n;
            fall_bit <= fall_n;
            lane_en  <= lane_n;
`ifdef DUALEDGE_SCHED_PARITY_EN
            par_q    <= par_n;
`endif
        end
    end

endmodule
`default_nettype wire
